// File: rtl/div_issue_queue_if.sv
// Dispatch, CDB and divider-issue signal bundle for the divide reservation station.
// The master side is the surrounding pipeline; the slave side is the queue.
interface div_issue_queue_if #(
  parameter int XLEN   = 32,
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6,
  parameter int ROB_W  = 4
);
  logic              disp_valid;
  logic              disp_ready;
  logic [2:0]        disp_sub_op;
  logic [ARCH_W-1:0] disp_rd;
  logic [PHYS_W-1:0] disp_pd;
  logic [ROB_W-1:0]  disp_rob;
  logic              disp_we;
  logic [PHYS_W-1:0] disp_ps1;
  logic [PHYS_W-1:0] disp_ps2;
  logic              disp_ps1_rdy;
  logic              disp_ps2_rdy;
  logic [XLEN-1:0]   disp_ps1_val;
  logic [XLEN-1:0]   disp_ps2_val;

  logic              cdb_valid;
  logic [PHYS_W-1:0] cdb_pd;
  logic [XLEN-1:0]   cdb_value;

  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [2:0]        sub_op;
  logic [ARCH_W-1:0] rd_arch;
  logic [PHYS_W-1:0] pd_phys;
  logic [ROB_W-1:0]  rob_idx;
  logic              dest_we;

  modport master (
    output disp_valid, disp_sub_op, disp_rd, disp_pd, disp_rob, disp_we,
           disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy, disp_ps1_val, disp_ps2_val,
           cdb_valid, cdb_pd, cdb_value, req_ready,
    input  disp_ready, req_valid, op_a, op_b, sub_op, rd_arch, pd_phys, rob_idx, dest_we
  );

  modport slave (
    input  disp_valid, disp_sub_op, disp_rd, disp_pd, disp_rob, disp_we,
           disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy, disp_ps1_val, disp_ps2_val,
           cdb_valid, cdb_pd, cdb_value, req_ready,
    output disp_ready, req_valid, op_a, op_b, sub_op, rd_arch, pd_phys, rob_idx, dest_we
  );
endinterface

// File: rtl/div_issue_queue.sv
// Age-ordered, compacting reservation station for the divide unit.
// Slot 0 is the oldest entry; the oldest fully-ready entry is offered to the divider.
module div_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6,
  parameter int ROB_W  = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  div_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]        op;
    logic [ARCH_W-1:0] rd;
    logic [PHYS_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic              we;
    logic [PHYS_W-1:0] ps1;
    logic [PHYS_W-1:0] ps2;
    logic              r1;
    logic              r2;
    logic [XLEN-1:0]   v1;
    logic [XLEN-1:0]   v2;
  } entry_t;

  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [CW-1:0] wr_pos;
  entry_t        slots   [DEPTH];
  entry_t        woken   [DEPTH];
  entry_t        shifted [DEPTH];
  entry_t        new_ent;
  logic [IW-1:0] sel;
  logic          found;
  logic          issue_fire;
  logic          disp_fire;
  int unsigned   src;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && (CW'(i) < count) && slots[i].r1 && slots[i].r2) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  always_comb begin
    bus.req_valid  = found;
    bus.disp_ready = (count < CW'(DEPTH));
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.sub_op     = '0;
    bus.rd_arch    = '0;
    bus.pd_phys    = '0;
    bus.rob_idx    = '0;
    bus.dest_we    = 1'b0;
    if (found) begin
      bus.op_a    = slots[sel].v1;
      bus.op_b    = slots[sel].v2;
      bus.sub_op  = slots[sel].op;
      bus.rd_arch = slots[sel].rd;
      bus.pd_phys = slots[sel].pd;
      bus.rob_idx = slots[sel].rob;
      bus.dest_we = slots[sel].we;
    end
  end

  assign issue_fire = found && bus.req_ready;
  assign disp_fire  = bus.disp_valid && (count < CW'(DEPTH)) && !flush;
  assign wr_pos     = count - CW'(issue_fire);
  assign count_n    = count + CW'(disp_fire) - CW'(issue_fire);

  always_comb begin
    new_ent     = '0;
    new_ent.op  = bus.disp_sub_op;
    new_ent.rd  = bus.disp_rd;
    new_ent.pd  = bus.disp_pd;
    new_ent.rob = bus.disp_rob;
    new_ent.we  = bus.disp_we;
    new_ent.ps1 = bus.disp_ps1;
    new_ent.ps2 = bus.disp_ps2;
    new_ent.r1  = bus.disp_ps1_rdy || (bus.cdb_valid && (bus.cdb_pd == bus.disp_ps1));
    new_ent.r2  = bus.disp_ps2_rdy || (bus.cdb_valid && (bus.cdb_pd == bus.disp_ps2));
    new_ent.v1  = bus.disp_ps1_rdy ? bus.disp_ps1_val : bus.cdb_value;
    new_ent.v2  = bus.disp_ps2_rdy ? bus.disp_ps2_val : bus.cdb_value;
  end

  // Wakeup acts on pre-shift slots, then each slot above the issued one moves
  // down by one, so a broadcast landing on a shifting entry is carried along.
  always_comb begin
    src = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = slots[i];
      if (bus.cdb_valid && (CW'(i) < count)) begin
        if (!slots[i].r1 && (slots[i].ps1 == bus.cdb_pd)) begin
          woken[i].r1 = 1'b1;
          woken[i].v1 = bus.cdb_value;
        end
        if (!slots[i].r2 && (slots[i].ps2 == bus.cdb_pd)) begin
          woken[i].r2 = 1'b1;
          woken[i].v2 = bus.cdb_value;
        end
      end
    end
    for (int unsigned j = 0; j < DEPTH; j++) begin
      src = j;
      if (issue_fire && (IW'(j) >= sel) && (j + 1 < DEPTH)) src = j + 1;
      shifted[j] = woken[src];
    end
    if (disp_fire) shifted[IW'(wr_pos)] = new_ent;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else              count <= count_n;
    slots <= shifted;
  end
endmodule
